// File: rtl/sensor_frame_packer.sv
// ----------------------------------------------------------------------------
// sensor_frame_packer
//   Queues tagged sensor samples {id, data} in a small circular FIFO and
//   serialises each one, byte by byte, to a uart_tx core as the frame
//   {ID, DATA[15:8], DATA[7:0], NL_BYTE}. Samples that arrive while a frame is
//   in flight wait in the FIFO; samples that arrive while it is full are
//   dropped and counted.
//
//   Optional feature: define SENSOR_FRAME_CHECKSUM_EN to insert a checksum
//   byte CHK = ID ^ DATA[15:8] ^ DATA[7:0] before the terminator (5-byte frame).
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous reset, active-high
//   in_valid     in   sample strobe, one sample per high cycle
//   in_id        in   8-bit sensor ID tag
//   in_data      in   16-bit sample value
//   in_ready     out  FIFO not full (from registered level)
//   tx_start     out  start request to uart_tx (registered)
//   tx_data      out  byte to send, stable while tx_start=1 (registered)
//   tx_busy      in   uart_tx busy flag
//   fifo_level   out  FIFO occupancy, 0..DEPTH
//   drop_cnt     out  samples rejected while full, saturates at 255
//   frames_sent  out  completed frames, wraps at 16 bits
// ----------------------------------------------------------------------------
module sensor_frame_packer #(
  parameter int         DEPTH      = 4,
  parameter int         GAP_CYCLES = 2000,
  parameter logic [7:0] NL_BYTE    = 8'h0A
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_id,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_busy,
  output logic [4:0]  fifo_level,
  output logic [7:0]  drop_cnt,
  output logic [15:0] frames_sent
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Gap counter only needs to reach GAP_CYCLES-1.
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
  localparam logic [4:0]    DEPTH_L  = 5'(DEPTH);
`ifdef SENSOR_FRAME_CHECKSUM_EN
  localparam logic [2:0]    LAST_IDX = 3'd4;
`else
  localparam logic [2:0]    LAST_IDX = 3'd3;
`endif

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

`ifdef SENSOR_FRAME_CHECKSUM_EN
  function automatic logic [7:0] frame_chk(input logic [23:0] f);
    return f[23:16] ^ f[15:8] ^ f[7:0];
  endfunction
`endif

  // Selects the byte of the frame that goes out at position idx.
  function automatic logic [7:0] frame_byte(input logic [23:0] f, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = f[23:16];
      3'd1:    b = f[15:8];
      3'd2:    b = f[7:0];
`ifdef SENSOR_FRAME_CHECKSUM_EN
      3'd3:    b = frame_chk(f);
`endif
      default: b = NL_BYTE;
    endcase
    return b;
  endfunction

  logic [23:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [4:0]    level_q, level_d;
  logic [7:0]    drop_q, drop_d;
  logic [15:0]   frames_q, frames_d;
  state_t        state_q, state_d;
  logic [23:0]   frame_q, frame_d;
  logic [2:0]    idx_q, idx_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          push_s, pop_s;

  // Push decision uses the registered level, so a full FIFO rejects even if
  // the FSM pops in the same cycle.
  assign push_s = in_valid && (level_q < DEPTH_L);
  assign pop_s  = (state_q == IDLE) && (level_q != 5'd0);

  assign in_ready    = (level_q < DEPTH_L);
  assign tx_start    = tx_start_q;
  assign tx_data     = tx_data_q;
  assign fifo_level  = level_q;
  assign drop_cnt    = drop_q;
  assign frames_sent = frames_q;

  // FIFO storage write port; contents need no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_id, in_data};
    end
  end

  // Next-state logic for FIFO bookkeeping, counters and the frame FSM.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    drop_d     = drop_q;
    frames_d   = frames_q;
    state_d    = state_q;
    frame_d    = frame_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    tx_start_d = tx_start_q;
    tx_data_d  = tx_data_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    if (in_valid && !push_s && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end else begin
      drop_d = drop_q;
    end

    case (state_q)
      IDLE: begin
        tx_start_d = 1'b0;
        if (pop_s) begin
          frame_d = mem_q[rd_ptr_q];
          idx_d   = 3'd0;
          state_d = START;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        // A busy flag already high here counts as the acknowledge.
        if (tx_busy) begin
          tx_start_d = 1'b0;
          state_d    = WAIT_DONE;
        end else begin
          tx_start_d = 1'b1;
          tx_data_d  = frame_byte(frame_q, idx_q);
        end
      end
      WAIT_DONE: begin
        tx_start_d = 1'b0;
        if (!tx_busy) begin
          gap_d   = '0;
          state_d = GAP;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      GAP: begin
        tx_start_d = 1'b0;
        if (gap_q == GAP_LAST) begin
          if (idx_q == LAST_IDX) begin
            frames_d = frames_q + 16'd1;
            state_d  = IDLE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = START;
          end
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame and empties the FIFO.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= 5'd0;
      drop_q     <= 8'd0;
      frames_q   <= 16'd0;
      state_q    <= IDLE;
      frame_q    <= 24'd0;
      idx_q      <= 3'd0;
      gap_q      <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      drop_q     <= drop_d;
      frames_q   <= frames_d;
      state_q    <= state_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

endmodule
